// File: rtl/seg7_pkg.sv
// Shared types and constants for the multi-digit seven-segment counter.
// Holds the segment encoding table and the tile input bit positions.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment patterns for nibble values 0..F, bit0 = segment a
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam int UI_RUN   = 0;
  localparam int UI_DOWN  = 1;
  localparam int UI_CLEAR = 2;
  localparam int UI_HEX   = 3;
  localparam int UI_LOAD  = 4;
  localparam int UI_BLANK = 5;

  localparam int UIO_PRESET_LSB = 4;
  localparam int UIO_PRESET_MSB = 7;

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to seven-segment pattern, forced dark when blank is set.
// Purely combinational; no handshake.
module seg7_decoder
  import seg7_pkg::*;
(
  input  digit_t     nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_CODES[nib];
    if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/tt_um_seven_segment_multidigit_ksandov4.sv
// Up/down BCD/hex counter with prescaled tick, scanned onto a shared segment bus.
// Outputs registered (1-cycle latency); ena=0 freezes every register.
module tt_um_seven_segment_multidigit_ksandov4
  import seg7_pkg::*;
#(
  parameter int TICK_DIV       = 10_000_000,
  parameter int SCAN_DIV       = 1024,
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] SEL_INV = (SEG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic run;
  logic down;
  logic clear;
  logic hex;
  logic load;
  logic blank_en;
  digit_t preset;

  assign run      = ui_in[UI_RUN];
  assign down     = ui_in[UI_DOWN];
  assign clear    = ui_in[UI_CLEAR];
  assign hex      = ui_in[UI_HEX];
  assign load     = ui_in[UI_LOAD];
  assign blank_en = ui_in[UI_BLANK];
  assign preset   = uio_in[UIO_PRESET_MSB:UIO_PRESET_LSB];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ui_in[7:6], uio_in[3:0]};

  digit_t [3:0]  count;
  digit_t [3:0]  next_count;
  digit_t [3:0]  load_count;
  logic [PW-1:0] presc;
  logic          tick_tgl;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    scan_idx;
  logic [7:0]    uo_q;
  logic [3:0]    sel_q;

  digit_t dmax;
  digit_t load_val;
  logic   carry;

  assign dmax     = hex ? 4'hF : 4'h9;
  assign load_val = (!hex && (preset > 4'd9)) ? 4'd9 : preset;

  // A stale hex digit in BCD mode counts as 9 going up and snaps to 9 going down
  always_comb begin
    next_count = count;
    load_count = '0;
    carry      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < NUM_DIGITS) begin
        load_count[i] = load_val;
        if (carry) begin
          if (!down) begin
            if (count[i] >= dmax) begin
              next_count[i] = '0;
            end else begin
              next_count[i] = count[i] + 4'd1;
              carry         = 1'b0;
            end
          end else begin
            if (count[i] == '0) begin
              next_count[i] = dmax;
            end else if (count[i] > dmax) begin
              next_count[i] = dmax;
              carry         = 1'b0;
            end else begin
              next_count[i] = count[i] - 4'd1;
              carry         = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      presc    <= '0;
      tick_tgl <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        count <= '0;
        presc <= '0;
      end else if (load) begin
        count <= load_count;
        presc <= '0;
      end else if (run) begin
        if (presc == PRESC_LAST) begin
          presc    <= '0;
          count    <= next_count;
          tick_tgl <= ~tick_tgl;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (ena) begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? 2'd0 : scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  // Blank a non-zero position when it and everything above it reads zero
  logic higher_nz;
  logic blank;

  always_comb begin
    higher_nz = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if ((j < NUM_DIGITS) && (2'(j) >= scan_idx) && (count[j] != '0)) begin
        higher_nz = 1'b1;
      end
    end
    blank = blank_en && (scan_idx != 2'd0) && !higher_nz;
  end

  logic [6:0] seg;

  seg7_decoder u_decoder (
    .nib   (count[scan_idx]),
    .blank (blank),
    .seg   (seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q  <= {1'b0, SEG_INV};
      sel_q <= SEL_INV;
    end else if (ena) begin
      uo_q  <= {tick_tgl, seg ^ SEG_INV};
      sel_q <= (4'b0001 << scan_idx) ^ SEL_INV;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {4'h0, sel_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: doc/tt_um_seven_segment_multidigit_ksandov4.md
# tt_um_seven_segment_multidigit_ksandov4

Parametrised multi-digit seven-segment counter for the TinyTapeout tile. It counts up or down in BCD or hex at a programmable tick rate and time-multiplexes up to four digits onto one shared segment bus. It supports pause, clear, preset load and leading-zero blanking. It uses the standard tile pin-out and drops in under the existing cocotb testbench harness.

## Interface
- `TICK_DIV`, default 10_000_000: clock cycles per count tick; minimum 2.
- `SCAN_DIV`, default 1024: clock cycles per displayed digit; minimum 1.
- `NUM_DIGITS`, default 4: number of digits, 1..4.
- `SEG_ACTIVE_LOW`, default 0: when 1, `uo_out[6:0]` and `uio_out[3:0]` are inverted at the output register.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset; clears all state.
- `ena` input 1: tile enable; when 0, prescaler, count and scan freeze and outputs hold.
- `ui_in` input 8: `[0]` run, `[1]` down, `[2]` clear, `[3]` hex mode, `[4]` load, `[5]` leading-zero blank, `[7:6]` unused.
- `uio_in` input 8: `[7:4]` preset nibble; `[3:0]` ignored.
- `uo_out` output 8: `[6:0]` segments a..g of the scanned digit (bit0 = a); `[7]` tick toggle.
- `uio_out` output 8: `[3:0]` one-hot digit select; `[7:4]` = 0.
- `uio_oe` output 8: constant `8'h0F`.

## Operation
- Inputs are used unsynchronised. The bench drives them away from the rising edge.
- Per-cycle priority with `ena`=1:
  1. clear: count and prescaler go to 0.
  2. load: every digit takes the preset nibble (clamped to 9 when not in hex mode); prescaler goes to 0.
  3. tick.
- Clear and load are level-sensitive and act every cycle they are high.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 only while run=1; pause holds its value.
  - A tick occurs in the cycle it equals `TICK_DIV`-1; the prescaler then returns to 0.
- Tick, up direction:
  - Digit 0 increments; carry ripples in the same cycle.
  - A digit wraps at 9 (BCD) or F (hex).
  - All digits at max wraps to all-zero.
- Tick, down direction:
  - Mirror of up; borrow ripples.
  - All-zero wraps to all-max (`NUM_DIGITS` nines or Fs).
- BCD mode with a stale hex digit above 9:
  - Up tick treats it as 9, so it wraps to 0 with carry.
  - Down tick sets it to 9.
- Each tick toggles `uo_out[7]`.
- Scan:
  - A divider of `SCAN_DIV` cycles advances the digit index 0..`NUM_DIGITS`-1 and wraps.
  - Scan runs regardless of run, clear and load.
- Leading-zero blank (`ui_in[5]`=1): digit i>0 is blanked (segments 0) when it and all higher digits are 0. Digit 0 is never blanked.
- Segment codes, bit0 = a:
  - 0..3: 3F, 06, 5B, 4F.
  - 4..7: 66, 6D, 7D, 07.
  - 8..B: 7F, 6F, 77, 7C.
  - C..F: 39, 5E, 79, 71.

## Timing
- Reset values, before any `SEG_ACTIVE_LOW` inversion:
  - `uo_out` = 00, `uio_out` = 00, `uio_oe` = 0F.
  - count 0, prescaler 0, scan index 0, scan divider 0, toggle 0.
- `uo_out` and `uio_out` are registered. They show the count and index as they stood at the previous edge, so latency is 1 cycle. The first display update lands on the first edge after reset release.
- A tick updates count on the terminal-prescaler edge. The segments show the new value one edge later.
- Clear or load with `ena`=1 updates count on the same edge. Clear or load in the tick cycle suppresses that tick and its toggle.
- Direction or mode changes apply to the next tick only; no retroactive correction.
- With `ena`=0 every register holds, including the output registers.
- Reset asserted mid-count asynchronously forces all reset values. Counting resumes from 0 after release.

## Structure
- Package `seg7_pkg`:
  - 16-entry segment encoding constant, and blank constant 7'h00.
  - `digit_t` (4-bit) typedef.
  - `ui_in`/`uio` bit-index constants.
- Sub-module `seg7_decoder` (combinational): nibble plus blank in, 7 segments out; instantiated once on the muxed digit.
- Digit counter chain, prescaler and scan logic stay in the top.

## Test plan
All scenarios use `TICK_DIV`=4, `SCAN_DIV`=2, `NUM_DIGITS`=4, active-high outputs.
- Reset: hold `rst_n`=0 → `uo_out`=00, `uio_out`=00, `uio_oe`=0F; release → next edge `uo_out[6:0]`=3F, `uio_out`=01, then 02, 04, 08, 01 every 2 cycles.
- Up BCD: run=1 for 40 cycles → count 0010; digit1 shows 06, digit0 shows 3F, `uo_out[7]` toggled 10 times (back to 0).
- Wrap: load preset 9 (count 9999), up tick → 0000, `uo_out[7]` toggles; pause mid-period holds prescaler and resume completes the period.
- Down hex: clear, hex=1, down=1, one tick → FFFF; all digits show 71; in BCD mode the same tick gives 9999 (6F).
- Blank: load preset 0, then 7 ticks up → 0007 with blank=1 → digits 3..1 segments 00, digit0 07; blank=0 → digits 3..1 show 3F.
- Priority and enable: clear and load high in a tick cycle → count 0000, no toggle; `ena`=0 for 20 cycles → all outputs and count unchanged; `rst_n` pulsed mid-count → immediate reset values.
